// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared types and constants for the NVRAM upload path
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [7:0] OOR_BYTE      = 8'hFF;
    localparam logic [7:0] DEFAULT_INDEX = 8'hFF;

endpackage

// File: rtl/nvram_uploader.sv
// rtl/nvram_uploader.sv - NVRAM read engine for data_io save upload with dirty tracking
// Optional: NVRAM_CHECKSUM_EN appends a two's-complement checksum byte at address 2^AW.
module nvram_uploader
    import nvram_pkg::*;
#(
    parameter int         AW    = 9,
    parameter logic [7:0] INDEX = DEFAULT_INDEX
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic [AW-1:0] ram_a,
    input  logic [7:0]    ram_q,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic          busy,
    output logic          dirty,
    output logic          upl_done
);

    localparam logic [24:0] NV_SIZE = 25'(2 ** AW);
`ifdef NVRAM_CHECKSUM_EN
    localparam logic [24:0] FINAL_ADDR = NV_SIZE;
`else
    localparam logic [24:0] FINAL_ADDR = NV_SIZE - 25'd1;
`endif

    state_t        state, state_nx;
    logic          active, active_q, rise, fall;
    logic          capture, fwd, req_in_range;
    logic [24:0]   last_addr;
    logic [AW-1:0] ram_a_q;
    logic          seen_last;
    logic [7:0]    cap_byte;

    assign active       = ioctl_upload && (ioctl_index == INDEX);
    assign rise         = active && !active_q;
    assign fall         = !active && active_q;
    assign capture      = (state == WAIT) && active;
    assign fwd          = cpu_we && (cpu_a == ram_a_q);
    assign req_in_range = ioctl_addr < NV_SIZE;
    assign busy         = (state != IDLE);

    // Address is presented combinationally in ISSUE so the RAM's registered read lands in WAIT.
    assign ram_a = (state == ISSUE && active && req_in_range) ? ioctl_addr[AW-1:0] : ram_a_q;

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] sum;
    logic [AW:0] exp_next;
    logic        sum_bad;
    logic        seq_ok;

    assign seq_ok = !sum_bad && (25'(exp_next) == NV_SIZE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum      <= 8'h00;
            exp_next <= '0;
            sum_bad  <= 1'b0;
        end else if (rise) begin
            sum      <= 8'h00;
            exp_next <= '0;
            sum_bad  <= 1'b0;
        end else if (capture && last_addr < NV_SIZE) begin
            if (last_addr == 25'(exp_next)) begin
                sum      <= sum + cap_byte;
                exp_next <= exp_next + 1'b1;
            end else begin
                sum_bad <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cap_byte = OOR_BYTE;
        if (last_addr < NV_SIZE) begin
            cap_byte = fwd ? cpu_d : ram_q;
        end
`ifdef NVRAM_CHECKSUM_EN
        else if (last_addr == NV_SIZE) begin
            cap_byte = seq_ok ? (8'h00 - sum) : 8'h00;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (active && (rise || ioctl_addr != last_addr)) state_nx = ISSUE;
            ISSUE:   state_nx = active ? WAIT : IDLE;
            WAIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= 1'b0;
            last_addr <= '1;
            ram_a_q   <= '0;
            ioctl_din <= OOR_BYTE;
            dirty     <= 1'b0;
            upl_done  <= 1'b0;
            seen_last <= 1'b0;
        end else begin
            active_q <= active;
            upl_done <= fall && seen_last;
            // A CPU write in the clear cycle must keep the save marked stale.
            if (cpu_we) begin
                dirty <= 1'b1;
            end else if (fall && seen_last) begin
                dirty <= 1'b0;
            end
            if (state == ISSUE && active) begin
                last_addr <= ioctl_addr;
                if (req_in_range) ram_a_q <= ioctl_addr[AW-1:0];
            end
            if (rise) begin
                seen_last <= 1'b0;
            end else if (capture && last_addr == FINAL_ADDR) begin
                seen_last <= 1'b1;
            end
            if (capture) ioctl_din <= cap_byte;
        end
    end

endmodule

// File: tb/tb_nvram_uploader.sv
// tb/tb_nvram_uploader.sv - randomized self-checking bench for nvram_uploader
module tb_nvram_uploader;

    localparam int NV = 512;
`ifdef NVRAM_CHECKSUM_EN
    localparam int FINAL = 512;
`else
    localparam int FINAL = 511;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic [8:0]  ram_a;
    logic [7:0]  ram_q;
    logic        cpu_we;
    logic [8:0]  cpu_a;
    logic [7:0]  cpu_d;
    logic        busy, dirty, upl_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram   [0:NV-1];
    logic [7:0] mem_m [0:NV-1];
    bit         dirty_m;
    bit         seen_m;
    int         capq[$];

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (cpu_we) ram[cpu_a] <= cpu_d;
        ram_q <= ram[ram_a];
    end

    nvram_uploader dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ram_a        (ram_a),
        .ram_q        (ram_q),
        .cpu_we       (cpu_we),
        .cpu_a        (cpu_a),
        .cpu_d        (cpu_d),
        .busy         (busy),
        .dirty        (dirty),
        .upl_done     (upl_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Saved image = the bytes, then (optionally) one byte making the total 0 mod 256
    // provided the upload so far was exactly 0,1,2,...,NV-1.
    function automatic logic [7:0] exp_of(input int a);
        logic [7:0] s;
        bit ok;
        if (a < NV) return mem_m[a];
`ifdef NVRAM_CHECKSUM_EN
        if (a == NV) begin
            ok = (capq.size() == NV);
            s  = 8'h00;
            foreach (capq[i]) begin
                if (capq[i] != i) ok = 0;
                s = s + mem_m[capq[i]];
            end
            return ok ? (8'h00 - s) : 8'h00;
        end
`endif
        return 8'hFF;
    endfunction

    task automatic cpu_write(input int a, input logic [7:0] d);
        cpu_we = 1'b1;
        cpu_a  = 9'(a);
        cpu_d  = d;
        tick();
        cpu_we = 1'b0;
        mem_m[a] = d;
        dirty_m  = 1;
    endtask

    task automatic fetch(input int a, input bit start);
        logic [7:0] e;
        if (start) begin
            ioctl_index  = 8'hFF;
            ioctl_upload = 1'b1;
            capq.delete();
            seen_m = 0;
        end
        ioctl_addr = 25'(a);
        e = exp_of(a);
        tick();
        check("busy_issue", 32'(busy), 32'd1);
        tick();
        tick();
        check($sformatf("din@%0d", a), 32'(ioctl_din), 32'(e));
        check("busy_idle", 32'(busy), 32'd0);
        if (a < NV) capq.push_back(a);
        if (a == FINAL) seen_m = 1;
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic end_upload(input bit wr);
        bit done;
        done = seen_m;
        ioctl_upload = 1'b0;
        if (wr) begin
            cpu_we = 1'b1;
            cpu_a  = 9'($urandom_range(0, NV - 1));
            cpu_d  = 8'($urandom);
            mem_m[cpu_a] = cpu_d;
        end
        tick();
        cpu_we = 1'b0;
        if (wr) dirty_m = 1;
        else if (done) dirty_m = 0;
        check("upl_done", 32'(upl_done), 32'(done));
        check("dirty_end", 32'(dirty), 32'(dirty_m));
        tick();
        check("upl_done_pulse", 32'(upl_done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a, prev;
        logic [8:0] ra;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'hFF;
        ioctl_addr   = '0;
        cpu_we       = 1'b0;
        cpu_a        = '0;
        cpu_d        = '0;
        dirty_m      = 0;
        seen_m       = 0;

        for (int i = 0; i < NV; i++) begin
            cpu_we = 1'b1;
            cpu_a  = 9'(i);
            cpu_d  = 8'(i);
            mem_m[i] = 8'(i);
            tick();
        end
        cpu_we = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        check("rst_din", 32'(ioctl_din), 32'hFF);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dirty", 32'(dirty), 32'd0);
        check("rst_upl_done", 32'(upl_done), 32'd0);

        for (int i = 0; i <= FINAL; i++) fetch(i, i == 0);
        end_upload(0);

        repeat (20) cpu_write($urandom_range(0, NV - 1), 8'($urandom));
        check("dirty_after_wr", 32'(dirty), 32'd1);

        prev = -1;
        for (int k = 0; k < 40; k++) begin
            do a = $urandom_range(0, 1023); while (a == prev || a == 511 || a == 512);
            ra = ram_a;
            fetch(a, k == 0);
            if (a >= NV) check("ram_a_hold", 32'(ram_a), 32'(ra));
            prev = a;
        end
        if (prev == 600) fetch(601, 0);
        ra = ram_a;
        fetch(600, 0);
        check("ram_a_hold_600", 32'(ram_a), 32'(ra));

        fetch(4, 0);
        ioctl_addr = 25'd5;
        tick();
        tick();
        check("fwd_ram_a", 32'(ram_a), 32'd5);
        cpu_we = 1'b1;
        cpu_a  = 9'd5;
        cpu_d  = 8'hA5;
        tick();
        cpu_we = 1'b0;
        mem_m[5] = 8'hA5;
        dirty_m  = 1;
        check("fwd_din", 32'(ioctl_din), 32'hA5);
        capq.push_back(5);

        ioctl_addr = 25'd100;
        tick();
        check("abort_busy", 32'(busy), 32'd1);
        ioctl_upload = 1'b0;
        tick();
        check("abort_upl_done", 32'(upl_done), 32'd0);
        check("abort_dirty", 32'(dirty), 32'd1);
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_din_hold", 32'(ioctl_din), 32'hA5);

        ioctl_index  = 8'h00;
        ioctl_upload = 1'b1;
        ioctl_addr   = 25'd7;
        repeat (4) begin
            tick();
            check("idx0_busy", 32'(busy), 32'd0);
        end
        check("idx0_din", 32'(ioctl_din), 32'hA5);
        ioctl_upload = 1'b0;
        ioctl_index  = 8'hFF;
        tick();

        fetch(FINAL, 1);
        end_upload(1);
        fetch(FINAL, 1);
        end_upload(0);

`ifdef NVRAM_CHECKSUM_EN
        for (int i = 0; i < NV; i++) cpu_write(i, 8'h01);
        for (int i = 0; i <= NV; i++) fetch(i, i == 0);
        end_upload(0);
        for (int i = 0; i < NV; i++) cpu_write(i, (i == 511) ? 8'h03 : 8'h00);
        for (int i = 0; i <= NV; i++) fetch(i, i == 0);
        end_upload(0);
        fetch(0, 1);
        fetch(2, 0);
        fetch(NV, 0);
        end_upload(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nvram_uploader.md
# nvram_uploader

Read-side engine for the game NVRAM save path. It runs while the data_io upload (OSD "Save NVRAM") is active, fetches NVRAM bytes through a dedicated read port, and presents them on `ioctl_din` in step with data_io's `ioctl_addr`. It also tracks whether the CPU has modified NVRAM since the last complete save (`dirty`). It sits beside the game core's NVRAM, which is a dual-port RAM: the CPU owns port A, and this block owns port B in read-only mode.

## Interface
Parameters:
- `AW`, 9, NVRAM address width; NVRAM size is 2^AW bytes.
- `INDEX`, 8'hFF, `ioctl_index` value that selects NVRAM upload.

Ports:
- `clk_sys`  in  1  system clock; data_io and CPU write strobes are in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  data_io upload active.
- `ioctl_index`  in  8  upload target selector.
- `ioctl_addr`  in  25  byte address requested by data_io.
- `ioctl_din`  out  8  byte for the current `ioctl_addr` (registered).
- `ram_a`  out  AW  NVRAM port-B address.
- `ram_q`  in  8  NVRAM port-B data; valid 1 cycle after `ram_a`.
- `cpu_we`  in  1  CPU NVRAM write strobe, single-cycle, already CE-qualified.
- `cpu_a`  in  AW  CPU write address.
- `cpu_d`  in  8  CPU write data.
- `busy`  out  1  a fetch is in flight.
- `dirty`  out  1  NVRAM modified since the last complete upload.
- `upl_done`  out  1  one-cycle pulse when a complete upload ends.

## Operation
- `active` = `ioctl_upload` && (`ioctl_index` == INDEX).
- FSM states:
  - IDLE: while `active`, any change of `ioctl_addr` from `last_addr` (or entry into `active`) → ISSUE.
  - ISSUE: drive `ram_a` = `ioctl_addr[AW-1:0]`, latch `last_addr` → WAIT.
  - WAIT: capture `ram_q` into `ioctl_din` → IDLE.
- Write forwarding: if `cpu_we` && `cpu_a` == `ram_a` in the WAIT cycle, capture `cpu_d` instead of `ram_q`.
- Out-of-range address (`ioctl_addr` ≥ 2^AW): no RAM access; `ioctl_din` = 8'hFF one cycle later. The checksum address is the exception (see Configuration).
- Coverage: `seen_last` is set when address 2^AW−1 is captured. It is cleared when `active` rises.
- `dirty` set by any `cpu_we`, whether or not an upload is in progress.
- `dirty` cleared on the falling edge of `active` when `seen_last` = 1; `upl_done` pulses in that same cycle.
- If `cpu_we` coincides with the clear cycle, `dirty` stays 1 (set wins).
- An upload aborted before `seen_last` leaves `dirty` unchanged and does not pulse `upl_done`.
- Loss of `active` mid-fetch: the FSM returns to IDLE next cycle, the pending capture is discarded, and `ioctl_din` holds its value.
- `ram_a` holds its last value outside ISSUE.

## Timing
- Reset values: `ioctl_din` = 8'hFF, `ram_a` = 0, `busy` = 0, `dirty` = 0, `upl_done` = 0, FSM = IDLE, `last_addr` = all-ones.
- Latency: `ioctl_din` is valid 3 clk_sys cycles after `ioctl_addr` changes (detect, ISSUE, WAIT/capture).
- data_io holds each address for far more than 3 cycles; no backpressure signal exists.
- `busy` is high in ISSUE and WAIT.
- A new address arriving during WAIT is handled right after the capture: IDLE detects the mismatch on the next cycle.

## Configuration
- `NVRAM_CHECKSUM_EN` defined:
  - An 8-bit running sum accumulates each in-range byte captured at address == `expected_next`. `expected_next` starts at 0 on `active` rise and increments per accepted byte.
  - Any non-sequential capture sets `sum_bad`.
  - At address 2^AW, `ioctl_din` = two's complement of the sum, so bytes plus checksum total 0 mod 256. If `sum_bad`, it returns 8'h00.
  - `seen_last` requires the checksum byte to be captured.
- Macro undefined: no accumulator; address 2^AW behaves as out-of-range (8'hFF).

## Structure
- Shared package `nvram_pkg`: FSM state enum (IDLE/ISSUE/WAIT), `OOR_BYTE` = 8'hFF, default `INDEX`.
- No sub-modules; the checksum accumulator is inline under the macro.

## Test plan
- Preload NVRAM[0..511] = addr[7:0]; sequential upload 0..511 → each `ioctl_din` equals the low address byte 3 cycles after the step; at the end, `upl_done` pulses and `dirty` = 0.
- `cpu_we` to address 5 with data 8'hA5 while fetching address 5 in WAIT → `ioctl_din` = 8'hA5.
- Upload aborted at address 100 → no `upl_done`; `dirty` keeps its prior value of 1.
- `ioctl_addr` = 600 → `ioctl_din` = 8'hFF, no `ram_a` change; `ioctl_index` = 0 → block stays idle.
- `cpu_we` in the same cycle as a complete-upload end → `upl_done` = 1 and `dirty` remains 1.
- With `NVRAM_CHECKSUM_EN`: all bytes 8'h01 → byte 512 = 8'h00 (sum 512 mod 256 = 0). Bytes 0..510 = 0 and byte 511 = 8'h03 → 8'hFD. An out-of-order request → 8'h00.
